d_cache_ctrl: RTL and testbench

Write-back, write-allocate, direct-mapped data cache placed between the CPU MEM stage and a line-wide main memory. Read and write hits complete in the same cycle the pipeline presents them. A miss raises `stall` until the victim line has been written back (if dirty) and the new line has been fetched. The pipeline freezes all stages while `stall` is high and holds the request stable.

---
 rtl/d_cache_ctrl_if.sv | 47 ++++
 rtl/d_cache_ctrl.sv | 167 ++++++++++++++++
 tb/tb_d_cache_ctrl.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/d_cache_ctrl_if.sv
// Bus bundle for the data cache: CPU MEM-stage request/response on one side
// and the line-wide main-memory port on the other. The cache uses the slave
// view; the pipeline/memory environment uses the master view.
interface d_cache_ctrl_if;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] cpu_rdata;
    logic        stall;
    logic [13:0] mem_addr;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_rdy;

    modport slave (
        input  cpu_addr,
        input  cpu_wdata,
        input  cpu_rd,
        input  cpu_wr,
        output cpu_rdata,
        output stall,
        output mem_addr,
        output mem_rd_req,
        output mem_wr_req,
        output mem_wdata,
        input  mem_rdata,
        input  mem_rdy
    );

    modport master (
        output cpu_addr,
        output cpu_wdata,
        output cpu_rd,
        output cpu_wr,
        input  cpu_rdata,
        input  stall,
        input  mem_addr,
        input  mem_rd_req,
        input  mem_wr_req,
        input  mem_wdata,
        output mem_rdata,
        output mem_rdy
    );
endinterface

// File: rtl/d_cache_ctrl.sv
// Write-back, write-allocate, direct-mapped data cache controller.
// 8 lines x 4 words x 16 bits. Hits complete combinationally in the same
// cycle; misses stall the pipeline while the victim is written back (if
// dirty) and the new line is fetched. The miss tag/index are latched when
// the miss is detected so the memory transaction stays coherent even if the
// CPU drops or changes its request part-way through.
module d_cache_ctrl (
    input  logic          clk,
    input  logic          rst_n,
    d_cache_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WRBACK = 2'd1,
        ALLOC  = 2'd2
    } state_t;

    state_t      state_r;
    state_t      next_state_s;

    // Per-line state and storage
    logic [7:0]  valid_r;
    logic [7:0]  dirty_r;
    logic [10:0] tag_r  [8];
    logic [63:0] line_r [8];

    // Latched miss address
    logic [10:0] miss_tag_r;
    logic [2:0]  miss_idx_r;

    // Request decode
    logic [10:0] req_tag_s;
    logic [2:0]  req_idx_s;
    logic [1:0]  req_off_s;
    logic        access_s;
    logic        hit_s;
    logic        wr_hit_s;
    logic [15:0] hit_word_s;

    // FSM control strobes
    logic        miss_start_s;
    logic        wb_done_s;
    logic        fill_s;
    logic        mem_rd_req_s;
    logic        mem_wr_req_s;
    logic [13:0] mem_addr_s;
    logic [63:0] mem_wdata_s;

    assign req_tag_s  = bus.cpu_addr[15:5];
    assign req_idx_s  = bus.cpu_addr[4:2];
    assign req_off_s  = bus.cpu_addr[1:0];
    assign access_s   = bus.cpu_rd | bus.cpu_wr;
    assign hit_s      = valid_r[req_idx_s] & (tag_r[req_idx_s] == req_tag_s);
    assign hit_word_s = line_r[req_idx_s][{req_off_s, 4'd0} +: 16];

    // A store wins over a simultaneous load; hits only retire in IDLE.
    assign wr_hit_s   = (state_r == IDLE) & bus.cpu_wr & hit_s;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and memory-port decode
    always_comb begin
        next_state_s = state_r;
        miss_start_s = 1'b0;
        wb_done_s    = 1'b0;
        fill_s       = 1'b0;
        mem_rd_req_s = 1'b0;
        mem_wr_req_s = 1'b0;
        mem_addr_s   = 14'd0;
        mem_wdata_s  = 64'd0;
        case (state_r)
            IDLE: begin
                // mem_rdy is deliberately not looked at here
                if (access_s && !hit_s) begin
                    miss_start_s = 1'b1;
                    if (valid_r[req_idx_s] && dirty_r[req_idx_s]) begin
                        next_state_s = WRBACK;
                    end else begin
                        next_state_s = ALLOC;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            WRBACK: begin
                mem_wr_req_s = 1'b1;
                mem_addr_s   = {tag_r[miss_idx_r], miss_idx_r};
                mem_wdata_s  = line_r[miss_idx_r];
                if (bus.mem_rdy) begin
                    wb_done_s    = 1'b1;
                    next_state_s = ALLOC;
                end else begin
                    next_state_s = WRBACK;
                end
            end
            ALLOC: begin
                mem_rd_req_s = 1'b1;
                mem_addr_s   = {miss_tag_r, miss_idx_r};
                if (bus.mem_rdy) begin
                    fill_s       = 1'b1;
                    next_state_s = IDLE;
                end else begin
                    next_state_s = ALLOC;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Capture the missing address at the moment the miss is detected
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miss_tag_r <= 11'd0;
            miss_idx_r <= 3'd0;
        end else if (miss_start_s) begin
            miss_tag_r <= req_tag_s;
            miss_idx_r <= req_idx_s;
        end
    end

    // Valid/dirty bookkeeping: fill, write-back completion, store hit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 8'd0;
            dirty_r <= 8'd0;
        end else if (fill_s) begin
            valid_r[miss_idx_r] <= 1'b1;
            dirty_r[miss_idx_r] <= 1'b0;
        end else if (wb_done_s) begin
            dirty_r[miss_idx_r] <= 1'b0;
        end else if (wr_hit_s) begin
            dirty_r[req_idx_s] <= 1'b1;
        end
    end

    // Tag and data arrays: line fill or single-word store merge
    always_ff @(posedge clk) begin
        if (fill_s) begin
            line_r[miss_idx_r] <= bus.mem_rdata;
            tag_r[miss_idx_r]  <= miss_tag_r;
        end else if (wr_hit_s) begin
            line_r[req_idx_s][{req_off_s, 4'd0} +: 16] <= bus.cpu_wdata;
        end
    end

    // CPU-side outputs are combinational; forced quiet while in reset.
    // Load data is only returned for a pure load that hits in IDLE.
    assign bus.stall     = rst_n & ((state_r != IDLE) | (access_s & ~hit_s));
    assign bus.cpu_rdata = (rst_n && (state_r == IDLE) && bus.cpu_rd && !bus.cpu_wr && hit_s)
                           ? hit_word_s : 16'd0;

    assign bus.mem_rd_req = mem_rd_req_s;
    assign bus.mem_wr_req = mem_wr_req_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_wdata  = mem_wdata_s;

endmodule

// File: tb/tb_d_cache_ctrl.sv
// Directed bench for d_cache_ctrl. Expectations are queued as each step's
// stimulus is applied and drained against the DUT outputs once they settle.
module tb_d_cache_ctrl;

    localparam int S_STALL = 0;
    localparam int S_RDREQ = 1;
    localparam int S_WRREQ = 2;
    localparam int S_ADDR  = 3;
    localparam int S_WDATA = 4;
    localparam int S_RDATA = 5;
    localparam int S_SCNT  = 6;

    typedef struct {
        int          sig;
        string       tag;
        logic [63:0] exp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   stall_cnt = 0;

    always #5 clk = ~clk;

    d_cache_ctrl_if bus();

    d_cache_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    function automatic logic [63:0] cur(input int sig);
        case (sig)
            S_STALL: cur = {63'd0, bus.stall};
            S_RDREQ: cur = {63'd0, bus.mem_rd_req};
            S_WRREQ: cur = {63'd0, bus.mem_wr_req};
            S_ADDR:  cur = {50'd0, bus.mem_addr};
            S_WDATA: cur = bus.mem_wdata;
            S_RDATA: cur = {48'd0, bus.cpu_rdata};
            S_SCNT:  cur = 64'(stall_cnt);
            default: cur = {64{1'b1}};
        endcase
    endfunction

    task automatic expect_val(input int sig, input string tag, input logic [63:0] exp);
        exp_t e;
        e.sig = sig;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        exp_t e;
        logic [63:0] obs;
        #1;
        if (bus.stall === 1'b1) stall_cnt++;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            obs = cur(e.sig);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        rst_n          = 1'b1;
        bus.cpu_addr   = 16'h0125;
        bus.cpu_wdata  = 16'h0000;
        bus.cpu_rd     = 1'b1;
        bus.cpu_wr     = 1'b0;
        bus.mem_rdata  = 64'd0;
        bus.mem_rdy    = 1'b0;
        #1 rst_n = 1'b0;
        cycle();
        cycle();
        // Reset: all outputs quiet even with a request present
        expect_val(S_STALL, "rst_stall", 64'd0);
        expect_val(S_RDREQ, "rst_rdreq", 64'd0);
        expect_val(S_WRREQ, "rst_wrreq", 64'd0);
        expect_val(S_ADDR,  "rst_addr",  64'd0);
        expect_val(S_WDATA, "rst_wdata", 64'd0);
        expect_val(S_RDATA, "rst_rdata", 64'd0);
        settle();

        // 1: cold read miss of 0x0025, fill after 3 request cycles
        cycle();
        rst_n = 1'b1;
        bus.cpu_addr = 16'h0025;
        stall_cnt = 0;
        expect_val(S_STALL, "t1_miss_stall", 64'd1);
        expect_val(S_RDREQ, "t1_idle_rdreq", 64'd0);
        expect_val(S_RDATA, "t1_miss_rdata", 64'd0);
        settle();
        cycle();
        expect_val(S_STALL, "t1_alloc_stall", 64'd1);
        expect_val(S_RDREQ, "t1_alloc_rdreq", 64'd1);
        expect_val(S_WRREQ, "t1_alloc_wrreq", 64'd0);
        expect_val(S_ADDR,  "t1_alloc_addr", 64'h0009);
        settle();
        cycle();
        expect_val(S_RDREQ, "t1_rdreq_hold", 64'd1);
        settle();
        cycle();
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'h4444_3333_2222_1111;
        expect_val(S_RDREQ, "t1_rdreq_at_rdy", 64'd1);
        settle();
        cycle();
        expect_val(S_STALL, "t1_done_stall", 64'd0);
        expect_val(S_RDATA, "t1_done_rdata", 64'h2222);
        expect_val(S_RDREQ, "t1_done_rdreq", 64'd0);
        expect_val(S_SCNT,  "t1_stall_cycles", 64'd4);
        settle();
        cycle();
        bus.mem_rdy = 1'b0;
        expect_val(S_STALL, "t1_rdy_ignored_stall", 64'd0);
        expect_val(S_RDREQ, "t1_rdy_ignored_rdreq", 64'd0);
        expect_val(S_RDATA, "t1_rdy_ignored_rdata", 64'h2222);
        settle();

        // 2: write hit then read back
        cycle();
        bus.cpu_rd    = 1'b0;
        bus.cpu_wr    = 1'b1;
        bus.cpu_addr  = 16'h0026;
        bus.cpu_wdata = 16'hBEEF;
        expect_val(S_STALL, "t2_wr_stall", 64'd0);
        expect_val(S_RDATA, "t2_wr_rdata", 64'd0);
        settle();
        cycle();
        bus.cpu_wr = 1'b0;
        bus.cpu_rd = 1'b1;
        expect_val(S_STALL, "t2_rd_stall", 64'd0);
        expect_val(S_RDATA, "t2_rd_rdata", 64'hBEEF);
        settle();

        // 3: dirty conflict on index 1
        cycle();
        bus.cpu_addr = 16'h0125;
        stall_cnt = 0;
        expect_val(S_STALL, "t3_miss_stall", 64'd1);
        expect_val(S_WRREQ, "t3_idle_wrreq", 64'd0);
        settle();
        cycle();
        expect_val(S_WRREQ, "t3_wb_wrreq", 64'd1);
        expect_val(S_RDREQ, "t3_wb_rdreq", 64'd0);
        expect_val(S_ADDR,  "t3_wb_addr", 64'h0009);
        expect_val(S_WDATA, "t3_wb_wdata", 64'h4444_BEEF_2222_1111);
        settle();
        cycle();
        bus.mem_rdy = 1'b1;
        expect_val(S_WRREQ, "t3_wb_hold", 64'd1);
        settle();
        cycle();
        bus.mem_rdy = 1'b0;
        expect_val(S_RDREQ, "t3_alloc_rdreq", 64'd1);
        expect_val(S_WRREQ, "t3_alloc_wrreq", 64'd0);
        expect_val(S_ADDR,  "t3_alloc_addr", 64'h0049);
        expect_val(S_WDATA, "t3_alloc_wdata", 64'd0);
        settle();
        cycle();
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'h8888_7777_6666_5555;
        expect_val(S_RDREQ, "t3_alloc_hold", 64'd1);
        settle();
        cycle();
        bus.mem_rdy = 1'b0;
        expect_val(S_STALL, "t3_done_stall", 64'd0);
        expect_val(S_RDATA, "t3_done_rdata", 64'h6666);
        expect_val(S_SCNT,  "t3_stall_cycles", 64'd5);
        settle();

        // 4: clean conflict goes straight to fetch
        cycle();
        bus.cpu_addr = 16'h0025;
        stall_cnt = 0;
        expect_val(S_STALL, "t4_miss_stall", 64'd1);
        settle();
        cycle();
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'h4444_BEEF_2222_1111;
        expect_val(S_RDREQ, "t4_rdreq", 64'd1);
        expect_val(S_WRREQ, "t4_no_wrreq", 64'd0);
        expect_val(S_ADDR,  "t4_addr", 64'h0009);
        settle();
        cycle();
        bus.mem_rdy = 1'b0;
        expect_val(S_STALL, "t4_done_stall", 64'd0);
        expect_val(S_RDATA, "t4_done_rdata", 64'h2222);
        expect_val(S_SCNT,  "t4_stall_cycles", 64'd2);
        settle();
        cycle();
        bus.cpu_addr = 16'h0026;
        expect_val(S_RDATA, "t4_word2_rdata", 64'hBEEF);
        settle();

        // 5: reset in the middle of a fetch
        cycle();
        bus.cpu_addr = 16'h0125;
        expect_val(S_STALL, "t5_miss_stall", 64'd1);
        settle();
        cycle();
        expect_val(S_RDREQ, "t5_alloc_rdreq", 64'd1);
        expect_val(S_ADDR,  "t5_alloc_addr", 64'h0049);
        settle();
        #2;
        rst_n = 1'b0;
        expect_val(S_RDREQ, "t5_rst_rdreq", 64'd0);
        expect_val(S_STALL, "t5_rst_stall", 64'd0);
        expect_val(S_ADDR,  "t5_rst_addr", 64'd0);
        settle();
        cycle();
        rst_n = 1'b1;
        bus.cpu_addr = 16'h0025;
        expect_val(S_STALL, "t5_remiss_stall", 64'd1);
        expect_val(S_RDATA, "t5_remiss_rdata", 64'd0);
        settle();
        cycle();
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'h4444_BEEF_2222_1111;
        expect_val(S_RDREQ, "t5_refetch_rdreq", 64'd1);
        expect_val(S_ADDR,  "t5_refetch_addr", 64'h0009);
        settle();
        cycle();
        bus.mem_rdy = 1'b0;
        expect_val(S_STALL, "t5_done_stall", 64'd0);
        expect_val(S_RDATA, "t5_done_rdata", 64'h2222);
        settle();

        // 6: simultaneous load+store behaves as a store
        cycle();
        bus.cpu_wr    = 1'b1;
        bus.cpu_wdata = 16'h1234;
        expect_val(S_STALL, "t6_rw_stall", 64'd0);
        expect_val(S_RDATA, "t6_rw_rdata", 64'd0);
        settle();
        cycle();
        bus.cpu_wr = 1'b0;
        expect_val(S_RDATA, "t6_readback", 64'h1234);
        settle();
        // The merged store marked the line dirty: conflict forces write-back
        cycle();
        bus.cpu_addr = 16'h0125;
        expect_val(S_STALL, "t6_miss_stall", 64'd1);
        settle();
        cycle();
        bus.mem_rdy = 1'b1;
        expect_val(S_WRREQ, "t6_wb_wrreq", 64'd1);
        expect_val(S_ADDR,  "t6_wb_addr", 64'h0009);
        expect_val(S_WDATA, "t6_wb_wdata", 64'h4444_BEEF_1234_1111);
        settle();
        // CPU drops its request; the fetch still runs to completion
        cycle();
        bus.mem_rdy = 1'b0;
        bus.cpu_rd  = 1'b0;
        expect_val(S_RDREQ, "t6_drop_rdreq", 64'd1);
        expect_val(S_ADDR,  "t6_drop_addr", 64'h0049);
        settle();
        cycle();
        bus.mem_rdy   = 1'b1;
        bus.mem_rdata = 64'hDDDD_CCCC_BBBB_AAAA;
        expect_val(S_RDREQ, "t6_drop_rdreq_hold", 64'd1);
        settle();
        cycle();
        bus.mem_rdy = 1'b0;
        expect_val(S_STALL, "t6_idle_stall", 64'd0);
        expect_val(S_RDREQ, "t6_idle_rdreq", 64'd0);
        expect_val(S_WRREQ, "t6_idle_wrreq", 64'd0);
        expect_val(S_ADDR,  "t6_idle_addr", 64'd0);
        settle();
        cycle();
        bus.cpu_rd   = 1'b1;
        bus.cpu_addr = 16'h0127;
        expect_val(S_STALL, "t6_hit_stall", 64'd0);
        expect_val(S_RDATA, "t6_hit_rdata", 64'hDDDD);
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
